// File: rtl/tpu_package.sv
// Shared TPU constants, weight-side state encoding and tile-count helper.
// Imported by the weight control unit and its fetch sequencer.
package tpu_package;

    localparam int MUL_SIZE = 32;
    localparam int WADDR_W  = 16;
    localparam int LOG2_MUL = $clog2(MUL_SIZE);
    localparam int ROW_W    = MUL_SIZE * 8;
    localparam int TILE_W   = 9;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FETCH,
        W_WAIT_SWAP,
        W_DRAIN
    } weight_state_t;

    // Tiles per operation: one more tile per dimension than whole MUL_SIZE blocks.
    function automatic logic [TILE_W-1:0] calc_tiles(
        input logic [8:0] h_dim,
        input logic [8:0] w_dim
    );
        logic [TILE_W-1:0] tiles_y;
        logic [TILE_W-1:0] tiles_x;
        tiles_y = TILE_W'(h_dim >> LOG2_MUL) + TILE_W'(1);
        tiles_x = TILE_W'(w_dim >> LOG2_MUL) + TILE_W'(1);
        return tiles_y * tiles_x;
    endfunction

endpackage

// File: rtl/weight_fetch_sequencer.sv
// Streams one weight tile out of memory: MUL_SIZE row reads, the matching
// shadow-register loads one cycle later, and a pulse on the last load.
module weight_fetch_sequencer
    import tpu_package::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [WADDR_W-1:0] i_base,
    output logic               o_rd,
    output logic [WADDR_W-1:0] o_addr,
    output logic               o_load,
    output logic               o_tile_done
);

    logic [LOG2_MUL-1:0] r_row;
    logic [WADDR_W-1:0]  r_addr;
    logic                r_rd;
    logic                r_load;
    logic                r_last;
    logic                w_last_row;

    assign w_last_row = (r_row == LOG2_MUL'(MUL_SIZE - 1));

    // Row read strobe and address walk; the address wraps with the memory.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd   <= 1'b0;
            r_addr <= '0;
            r_row  <= '0;
        end else if (i_start) begin
            r_rd   <= 1'b1;
            r_addr <= i_base;
            r_row  <= '0;
        end else if (r_rd) begin
            if (w_last_row) begin
                r_rd <= 1'b0;
            end else begin
                r_row  <= r_row + LOG2_MUL'(1);
                r_addr <= r_addr + WADDR_W'(1);
            end
        end
    end

    // Loads trail the reads by the one-cycle memory latency.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_load <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_load <= r_rd;
            r_last <= r_rd & w_last_row;
        end
    end

    assign o_rd        = r_rd;
    assign o_addr      = r_addr;
    assign o_load      = r_load;
    assign o_tile_done = r_last;

endmodule

// File: rtl/weight_control_unit.sv
// Weight-side controller: fetches tiles into the shadow registers, swaps them
// into the active array and tracks which tiles the compute side holds.
module weight_control_unit
    import tpu_package::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               instruction_i,
    input  logic [8:0]         H_DIM_i,
    input  logic [8:0]         W_DIM_i,
    input  logic [WADDR_W-1:0] weight_mem_start_addr_i,
    input  logic               next_weight_tile_i,
    output logic               weight_mem_rd_o,
    output logic [WADDR_W-1:0] weight_mem_addr_o,
    input  logic [ROW_W-1:0]   weight_mem_data_i,
    output logic [ROW_W-1:0]   weight_row_o,
    output logic               load_weights_o,
    output logic               swap_weights_o,
    output logic               compute_weights_rdy_o,
    output logic               compute_weights_buffered_o,
    output logic               busy_o,
    output logic               done_o
);

    weight_state_t      r_state;
    logic [TILE_W-1:0]  r_total;
    logic [TILE_W-1:0]  r_next_idx;
    logic [WADDR_W-1:0] r_start;
    logic               r_active_valid;
    logic               r_shadow_valid;
    logic               r_swap;
    logic               r_done;

    logic               w_consume;
    logic               w_more;
    logic               w_tile_done;
    logic               w_fetch_start;
    logic [WADDR_W-1:0] w_base;
    logic [WADDR_W-1:0] w_fetch_base;

    // A consume request only counts while the active array holds a tile.
    assign w_consume = next_weight_tile_i & r_active_valid;
    assign w_more    = (r_next_idx < r_total);
    assign w_base    = r_start + WADDR_W'({r_next_idx, {LOG2_MUL{1'b0}}});

    // Launch a tile fetch on start, or whenever a swap frees the shadow.
    always_comb begin
        w_fetch_start = 1'b0;
        w_fetch_base  = w_base;
        unique case (r_state)
            W_IDLE: begin
                w_fetch_start = instruction_i;
                w_fetch_base  = weight_mem_start_addr_i;
            end
            W_FETCH: begin
                w_fetch_start = w_tile_done & (~r_active_valid | w_consume)
                              & w_more;
            end
            W_WAIT_SWAP: begin
                w_fetch_start = w_consume & w_more;
            end
            default: begin
                w_fetch_start = 1'b0;
            end
        endcase
    end

    // Tile FSM with tile counters, valid flags and registered pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state        <= W_IDLE;
            r_total        <= '0;
            r_next_idx     <= '0;
            r_start        <= '0;
            r_active_valid <= 1'b0;
            r_shadow_valid <= 1'b0;
            r_swap         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_swap <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                W_IDLE: begin
                    if (instruction_i) begin
                        r_total        <= calc_tiles(H_DIM_i, W_DIM_i);
                        r_start        <= weight_mem_start_addr_i;
                        r_next_idx     <= TILE_W'(1);
                        r_active_valid <= 1'b0;
                        r_shadow_valid <= 1'b0;
                        r_state        <= W_FETCH;
                    end
                end
                W_FETCH: begin
                    if (w_tile_done) begin
                        if (!r_active_valid || w_consume) begin
                            r_swap         <= 1'b1;
                            r_active_valid <= 1'b1;
                            if (w_more) begin
                                r_next_idx <= r_next_idx + TILE_W'(1);
                            end else begin
                                r_state <= W_DRAIN;
                            end
                        end else begin
                            r_shadow_valid <= 1'b1;
                            r_state        <= W_WAIT_SWAP;
                        end
                    end else if (w_consume) begin
                        r_active_valid <= 1'b0;
                    end
                end
                W_WAIT_SWAP: begin
                    if (w_consume) begin
                        r_swap         <= 1'b1;
                        r_shadow_valid <= 1'b0;
                        if (w_more) begin
                            r_next_idx <= r_next_idx + TILE_W'(1);
                            r_state    <= W_FETCH;
                        end else begin
                            r_state <= W_DRAIN;
                        end
                    end
                end
                W_DRAIN: begin
                    if (w_consume) begin
                        r_done         <= 1'b1;
                        r_active_valid <= 1'b0;
                        r_state        <= W_IDLE;
                    end
                end
                default: begin
                    r_state <= W_IDLE;
                end
            endcase
        end
    end

    weight_fetch_sequencer u_seq (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_start     (w_fetch_start),
        .i_base      (w_fetch_base),
        .o_rd        (weight_mem_rd_o),
        .o_addr      (weight_mem_addr_o),
        .o_load      (load_weights_o),
        .o_tile_done (w_tile_done)
    );

    assign weight_row_o               = weight_mem_data_i;
    assign swap_weights_o             = r_swap;
    assign compute_weights_rdy_o      = r_active_valid;
    assign compute_weights_buffered_o = r_shadow_valid;
    assign busy_o                     = (r_state != W_IDLE);
    assign done_o                     = r_done;

endmodule

// File: tb/tb_weight_control_unit.sv
// Bench for weight_control_unit: directed timing scenarios plus randomized
// runs checked against a tile-counting reference model.
module tb_weight_control_unit;

    localparam int MS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          instr;
    logic          nwt;
    logic [8:0]    h_dim;
    logic [8:0]    w_dim;
    logic [15:0]   saddr;
    logic [MS*8-1:0] mdata;

    logic          rd;
    logic [15:0]   addr;
    logic [MS*8-1:0] row;
    logic          load;
    logic          swp;
    logic          rdy;
    logic          bufd;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    weight_control_unit dut (
        .clk_i                      (clk),
        .rst_i                      (rst),
        .instruction_i              (instr),
        .H_DIM_i                    (h_dim),
        .W_DIM_i                    (w_dim),
        .weight_mem_start_addr_i    (saddr),
        .next_weight_tile_i         (nwt),
        .weight_mem_rd_o            (rd),
        .weight_mem_addr_o          (addr),
        .weight_mem_data_i          (mdata),
        .weight_row_o               (row),
        .load_weights_o             (load),
        .swap_weights_o             (swp),
        .compute_weights_rdy_o      (rdy),
        .compute_weights_buffered_o (bufd),
        .busy_o                     (busy),
        .done_o                     (done)
    );

    logic [6:0] d_vec;
    assign d_vec = {rd, load, swp, rdy, bufd, busy, done};

    // Reference model: counts tiles issued and cycles elapsed in the current
    // fetch (1..MS reading, 2..MS+1 loading, tile ready after cycle MS+1).
    int          m_el, m_iss, m_total;
    bit          m_act, m_sh, m_busy, m_swap, m_done;
    logic [15:0] m_start;
    int          n_el, n_iss, n_total;
    bit          n_act, n_sh, n_busy, n_swap, n_done, take;
    logic [15:0] n_start;

    always_comb begin
        n_el = m_el; n_iss = m_iss; n_total = m_total; n_start = m_start;
        n_act = m_act; n_sh = m_sh; n_busy = m_busy;
        n_swap = 1'b0; n_done = 1'b0; take = 1'b0;
        if (!rst) begin
            n_el = 0; n_iss = 0; n_total = 0;
            n_act = 1'b0; n_sh = 1'b0; n_busy = 1'b0;
        end else if (!m_busy) begin
            if (instr) begin
                n_total = (int'(h_dim) / MS + 1) * (int'(w_dim) / MS + 1);
                n_start = saddr;
                n_iss = 1; n_el = 1; n_busy = 1'b1;
                n_act = 1'b0; n_sh = 1'b0;
            end
        end else begin
            take = nwt && m_act;
            if (m_el == MS + 1) begin
                if (!m_act || take) begin
                    n_swap = 1'b1; n_act = 1'b1;
                    if (m_iss < m_total) begin
                        n_iss = m_iss + 1; n_el = 1;
                    end else begin
                        n_el = 0;
                    end
                end else begin
                    n_sh = 1'b1; n_el = 0;
                end
            end else begin
                if (m_el > 0) n_el = m_el + 1;
                if (take) begin
                    if (m_sh) begin
                        n_swap = 1'b1; n_sh = 1'b0;
                        if (m_iss < m_total) begin
                            n_iss = m_iss + 1; n_el = 1;
                        end
                    end else if (m_el > 0) begin
                        n_act = 1'b0;
                    end else begin
                        n_done = 1'b1; n_act = 1'b0; n_busy = 1'b0;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        m_el <= n_el; m_iss <= n_iss; m_total <= n_total; m_start <= n_start;
        m_act <= n_act; m_sh <= n_sh; m_busy <= n_busy;
        m_swap <= n_swap; m_done <= n_done;
    end

    logic [6:0]  e_vec;
    logic [15:0] e_addr;
    assign e_vec = {(m_el >= 1 && m_el <= MS), (m_el >= 2 && m_el <= MS + 1),
                    m_swap, m_act, m_sh, m_busy, m_done};
    assign e_addr = m_start + 16'((m_iss - 1) * MS + m_el - 1);

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; instr = 1'b0; nwt = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (d_vec !== 7'b0 || addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_state got=%b/%h exp=0/0000", d_vec, addr);
        end
        rst = 1'b1;
        h_dim = 9'd63; w_dim = 9'd63; saddr = 16'h2000; instr = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if ({rd, busy} !== 2'b11) begin
                    errors++;
                    $display("FAIL reset_prefetch got=%b exp=11", {rd, busy});
                end
            end
            if (c >= 11 && c <= 14) begin
                checks++;
                if (d_vec !== 7'b0) begin
                    errors++;
                    $display("FAIL reset_abort c=%0d got=%b exp=0", c, d_vec);
                end
            end
            if (c == 15) begin
                checks++;
                if ({rd, busy, addr} !== {2'b11, 16'h3000}) begin
                    errors++;
                    $display("FAIL reset_restart got=%b/%h exp=11/3000",
                             {rd, busy}, addr);
                end
            end
            rst   = !(c >= 10 && c <= 12);
            instr = (c == 14);
            saddr = (c == 14) ? 16'h3000 : 16'h2000;
        end
    endtask

    task automatic test_single();
        logic [6:0] ev;
        do_reset();
        h_dim = 9'd31; w_dim = 9'd31; saddr = 16'h0100; instr = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            instr = 1'b0;
            ev = {(c >= 1 && c <= 32), (c >= 2 && c <= 33), (c == 34),
                  (c >= 34 && c <= 40), 1'b0, (c <= 40), (c == 41)};
            checks++;
            if (d_vec !== ev) begin
                errors++;
                $display("FAIL single c=%0d got=%b exp=%b", c, d_vec, ev);
            end
            if (c <= 32) begin
                checks++;
                if (addr !== 16'h0100 + 16'(c - 1)) begin
                    errors++;
                    $display("FAIL single_addr c=%0d got=%h exp=%h",
                             c, addr, 16'h0100 + 16'(c - 1));
                end
            end
            if (c == 5) begin
                for (int k = 0; k < MS / 4; k++) mdata[k*32 +: 32] = $urandom;
                #1;
                checks++;
                if (row !== mdata) begin
                    errors++;
                    $display("FAIL row_pass got=%h exp=%h", row, mdata);
                end
            end
            nwt = (c == 40);
        end
    endtask

    task automatic test_two_tiles();
        logic [6:0]  ev;
        logic [15:0] ea;
        do_reset();
        h_dim = 9'd63; w_dim = 9'd31; saddr = 16'h0100; instr = 1'b1;
        for (int c = 1; c <= 95; c++) begin
            @(negedge clk);
            instr = 1'b0;
            ev = {((c >= 1 && c <= 32) || (c >= 34 && c <= 65)),
                  ((c >= 2 && c <= 33) || (c >= 35 && c <= 66)),
                  (c == 34 || c == 81), (c >= 34 && c <= 90),
                  (c >= 67 && c <= 80), (c <= 90), (c == 91)};
            checks++;
            if (d_vec !== ev) begin
                errors++;
                $display("FAIL two_tiles c=%0d got=%b exp=%b", c, d_vec, ev);
            end
            if (c <= 32 || (c >= 34 && c <= 65)) begin
                ea = (c <= 32) ? 16'h0100 + 16'(c - 1) : 16'h0120 + 16'(c - 34);
                checks++;
                if (addr !== ea) begin
                    errors++;
                    $display("FAIL two_addr c=%0d got=%h exp=%h", c, addr, ea);
                end
            end
            nwt = (c == 80 || c == 90);
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] ev;
        do_reset();
        h_dim = 9'd63; w_dim = 9'd31; saddr = 16'h0800; instr = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            instr = 1'b0;
            ev = {((c >= 1 && c <= 32) || (c >= 34 && c <= 65)),
                  ((c >= 2 && c <= 33) || (c >= 35 && c <= 66)),
                  (c == 34 || c == 67), (c >= 34 && c <= 75),
                  1'b0, (c <= 75), (c == 76)};
            checks++;
            if (d_vec !== ev) begin
                errors++;
                $display("FAIL simultaneous c=%0d got=%b exp=%b", c, d_vec, ev);
            end
            nwt = (c == 66 || c == 75);
        end
    endtask

    task automatic test_wrap_ignore();
        logic [6:0]  ev;
        logic [15:0] ea;
        logic [15:0] base;
        do_reset();
        nwt = 1'b1;
        @(negedge clk);
        nwt = 1'b0;
        @(negedge clk);
        checks++;
        if (d_vec !== 7'b0) begin
            errors++;
            $display("FAIL idle_stray got=%b exp=0", d_vec);
        end
        base = 16'hFFF0;
        h_dim = 9'd63; w_dim = 9'd31; saddr = base; instr = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            ev = {((c >= 1 && c <= 32) || (c >= 34 && c <= 65)),
                  ((c >= 2 && c <= 33) || (c >= 35 && c <= 66)),
                  (c == 34 || c == 71), (c >= 34 && c <= 85),
                  (c >= 67 && c <= 70), (c <= 85), (c == 86)};
            checks++;
            if (d_vec !== ev) begin
                errors++;
                $display("FAIL wrap c=%0d got=%b exp=%b", c, d_vec, ev);
            end
            if (c <= 32 || (c >= 34 && c <= 65)) begin
                ea = (c <= 32) ? base + 16'(c - 1) : base + 16'(MS + c - 34);
                checks++;
                if (addr !== ea) begin
                    errors++;
                    $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, addr, ea);
                end
            end
            instr = (c == 10);
            saddr = (c == 10) ? 16'h4000 : base;
            h_dim = (c == 10) ? 9'd200 : 9'd63;
            nwt   = (c == 70 || c == 85);
        end
    endtask

    task automatic test_periodic();
        int swaps = 0;
        int dones = 0;
        do_reset();
        h_dim = 9'd63; w_dim = 9'd63; saddr = 16'h0400; instr = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            instr = 1'b0;
            checks++;
            if (d_vec !== e_vec) begin
                errors++;
                $display("FAIL periodic c=%0d got=%b exp=%b", c, d_vec, e_vec);
            end
            if (e_vec[6]) begin
                checks++;
                if (addr !== e_addr) begin
                    errors++;
                    $display("FAIL periodic_addr c=%0d got=%h exp=%h",
                             c, addr, e_addr);
                end
            end
            if (swp === 1'b1) swaps++;
            if (done === 1'b1) dones++;
            nwt = (c % 20 == 0);
        end
        checks++;
        if (swaps != 4 || dones != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL periodic_totals got=%0d/%0d/%b exp=4/1/0",
                     swaps, dones, busy);
        end
    endtask

    task automatic test_random();
        int  dones;
        bit  fin;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            h_dim = 9'($urandom_range(0, 100));
            w_dim = 9'($urandom_range(0, 100));
            saddr = 16'($urandom);
            instr = 1'b1;
            dones = 0;
            fin   = 1'b0;
            for (int c = 1; c <= 3000 && !fin; c++) begin
                @(negedge clk);
                checks++;
                if (d_vec !== e_vec) begin
                    errors++;
                    $display("FAIL random it=%0d c=%0d got=%b exp=%b",
                             it, c, d_vec, e_vec);
                end
                if (e_vec[6]) begin
                    checks++;
                    if (addr !== e_addr) begin
                        errors++;
                        $display("FAIL random_addr it=%0d c=%0d got=%h exp=%h",
                                 it, c, addr, e_addr);
                    end
                end
                if (done === 1'b1) dones++;
                if (done === 1'b1 || m_done) fin = 1'b1;
                instr = !fin && ($urandom_range(0, 30) == 0);
                nwt   = !fin && ($urandom_range(0, 3) == 0);
                for (int k = 0; k < MS / 4; k++) mdata[k*32 +: 32] = $urandom;
            end
            instr = 1'b0;
            nwt   = 1'b0;
            checks++;
            if (!fin || dones != 1) begin
                errors++;
                $display("FAIL random_done it=%0d got=%0d exp=1 finished=%0d",
                         it, dones, fin);
            end
        end
    endtask

    initial begin
        rst = 1'b0; instr = 1'b0; nwt = 1'b0;
        h_dim = '0; w_dim = '0; saddr = '0; mdata = '0;
        test_reset();
        test_single();
        test_two_tiles();
        test_simultaneous();
        test_wrap_ignore();
        test_periodic();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_control_unit.md
Name: weight_control_unit

Overview:
Weight-side partner of compute_control_unit. It fetches weight tiles from weight memory into the systolic array's shadow weight registers, one row per cycle. It swaps a full shadow tile into the active array and drives compute_weights_rdy/compute_weights_buffered. It advances to the next tile on the compute side's next_weight_tile pulse.

Parameters:
MUL_SIZE, 32 (from tpu_package), systolic array edge; one tile is MUL_SIZE rows of MUL_SIZE 8-bit weights
WADDR_W, 16, weight memory row-address width

Ports:
clk_i  in  1  clock; all logic on posedge
rst_i  in  1  synchronous, active-low reset
instruction_i  in  1  start pulse; ignored unless IDLE
H_DIM_i  in  9  activation height; tiles_y = (H_DIM_i>>log2(MUL_SIZE))+1
W_DIM_i  in  9  output width; tiles_x = (W_DIM_i>>log2(MUL_SIZE))+1
weight_mem_start_addr_i  in  WADDR_W  row address of tile 0
next_weight_tile_i  in  1  one-cycle pulse: active tile consumed
weight_mem_rd_o  out  1  row read strobe
weight_mem_addr_o  out  WADDR_W  row read address
weight_mem_data_i  in  MUL_SIZE*8  read data, valid 1 cycle after weight_mem_rd_o
weight_row_o  out  MUL_SIZE*8  combinational pass-through of weight_mem_data_i
load_weights_o  out  1  shift weight_row_o into shadow registers
swap_weights_o  out  1  one-cycle pulse: shadow -> active
compute_weights_rdy_o  out  1  active array holds an unconsumed tile
compute_weights_buffered_o  out  1  shadow holds a complete next tile
busy_o  out  1  high outside IDLE
done_o  out  1  one-cycle pulse when the last tile is consumed

Behaviour:
- Reset (rst_i==0 at posedge): all outputs 0; state IDLE; counters 0; active/shadow valid flags 0. A mid-operation reset aborts everything immediately, with no done_o.
- States: IDLE, FETCH, WAIT_SWAP, DRAIN.
- IDLE + instruction_i (cycle 0): latch dims and start address; total_tiles = tiles_x*tiles_y (9 bits, max 256); tile_idx = 0; go to FETCH.
- Tile order: y-inner, x-outer, matching the compute side. Tile k base address = start + k*MUL_SIZE, wrapping modulo 2^WADDR_W.
- FETCH: weight_mem_rd_o (registered) is high for exactly MUL_SIZE consecutive cycles, addr = base+row with row 0..MUL_SIZE-1. load_weights_o = rd delayed 1 cycle. The tile is complete in the cycle after the last load_weights_o.
- On tile completion:
  - If the active tile is not valid: swap_weights_o pulses and active_valid is set, so rdy rises in the same cycle as the swap.
  - If the active tile is valid: shadow_valid is set (buffered rises), go to WAIT_SWAP.
  - Reset-to-rdy latency: instruction at cycle 0, rd cycles 1..MUL_SIZE, loads 2..MUL_SIZE+1, swap and rdy at MUL_SIZE+2.
- Reads for tile k+1 start in the same cycle swap_weights_o pulses, if tile_idx+1 < total_tiles. Otherwise go to DRAIN.
- next_weight_tile_i, evaluated on the pre-edge state:
  - If buffered: next cycle swap pulses, buffered drops, rdy stays 1, and the next fetch starts.
  - If not buffered: rdy drops next cycle; the in-flight fetch continues and swaps on completion.
- Simultaneous tile completion and next_weight_tile_i: treated as not buffered. Swap in the completion cycle; rdy stays 1.
- DRAIN + next_weight_tile_i with no shadow tile and no remaining fetch: done_o pulses next cycle, rdy drops, return to IDLE.
- next_weight_tile_i while rdy==0, or in IDLE: ignored.
- compute_weights_buffered_o is registered and never high while rdy==0.

Decomposition:
- tpu_package gains MUL_SIZE (existing), WADDR_W, and the weight_state_t enum {W_IDLE, W_FETCH, W_WAIT_SWAP, W_DRAIN}.
- Sub-module weight_fetch_sequencer: row counter, address generation, rd→load delay pipeline, and the tile-complete pulse.
- The parent module holds the FSM, tile counters, and valid flags.

Test Plan:
- Reset low for 3 cycles during FETCH, then high -> all outputs 0, state IDLE, no done_o, instruction accepted after reset.
- H=31, W=31, start=0x100 -> rd at cycles 1..32 with addr 0x100..0x11F; loads at 2..33; swap and rdy at 34; busy high; a next_weight_tile pulse at 40 -> done_o at 41, busy low.
- H=63, W=31 (2 tiles) -> second fetch at addrs 0x120..0x13F starting cycle 34; buffered at 67; next_weight_tile at 80 -> swap at 81, rdy stays 1; second pulse -> done_o.
- H=63, W=63, next_weight_tile pulses every 20 cycles -> rdy drops until each fetch completes; 4 swaps total; done_o exactly once after the 4th consumed tile.
- Pulse next_weight_tile_i in the exact tile-completion cycle -> swap in the same cycle, buffered never asserts, rdy continuous.
- start=0xFFF0 with 2 tiles -> addresses wrap to 0x0000..; instruction_i while busy is ignored; stray next_weight_tile_i in IDLE has no effect.
